axi_master_ctrl: RTL

AXI4 master (initiator) engine that turns simple single-command requests into AXI4 INCR bursts toward the `axi_slave`. Local logic issues one read or write command with a start address and beat count. The block drives the AW/W/B or AR/R channels, streams data between the local ports and the bus, and reports one completion status per command. It sits between local control logic and the AXI fabric, and it is the DUT counterpart the verification environment drives against `axi_slave`.

---
 rtl/axi_master_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_master_ctrl.sv
// AXI4 master engine: turns one local read/write command into a single INCR burst
// and reports one completion status per command. One transaction outstanding at a time.
module axi_master_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   // local command
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [3:0]        cmd_len,
   input  logic [ID_W-1:0]   cmd_id,
   // local write data
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   // local read data
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   // completion
   output logic              done_valid,
   output logic [1:0]        done_resp,
   output logic [ID_W-1:0]   done_id,
   // AW channel
   output logic [ID_W-1:0]   awid,
   output logic [ADDR_W-1:0] awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic              awvalid,
   input  logic              awready,
   // W channel
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   // B channel
   input  logic [ID_W-1:0]   bid,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   // AR channel
   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   // R channel
   input  logic [ID_W-1:0]   rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);

   localparam int BYTES = DATA_W / 8;
   localparam int SIZE  = $clog2(BYTES);

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        len_q, len_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [1:0]        resp_q, resp_d;
   logic [3:0]        beat_q, beat_d;

   logic [31:0]       span;
   logic              crosses_4k;
   logic              st_idle, st_wa, st_wd, st_wr, st_ra, st_rd, st_done;

   // End offset of the burst within its 4 KB page; beyond 4096 it would straddle pages.
   assign span       = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) << SIZE);
   assign crosses_4k = span > 32'd4096;

   assign st_idle = (state_q == IDLE);
   assign st_wa   = (state_q == WR_ADDR);
   assign st_wd   = (state_q == WR_DATA);
   assign st_wr   = (state_q == WR_RESP);
   assign st_ra   = (state_q == RD_ADDR);
   assign st_rd   = (state_q == RD_DATA);
   assign st_done = (state_q == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         id_q    <= '0;
         resp_q  <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         id_q    <= id_d;
         resp_q  <= resp_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      id_d    = id_q;
      resp_d  = resp_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_d = cmd_addr;
               len_d  = cmd_len;
               id_d   = cmd_id;
               beat_d = '0;
               resp_d = 2'b00;
               if (crosses_4k) begin
                  resp_d  = 2'b10;
                  state_d = DONE;
               end else begin
                  state_d = cmd_write ? WR_ADDR : RD_ADDR;
               end
            end
         end
         WR_ADDR: if (awready) state_d = WR_DATA;
         WR_DATA: begin
            if (wr_valid && wready) begin
               beat_d = beat_q + 4'd1;
               if (beat_q == len_q) state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bvalid) begin
               resp_d  = (bid != id_q) ? 2'b10 : bresp;
               state_d = DONE;
            end
         end
         RD_ADDR: if (arready) state_d = RD_DATA;
         RD_DATA: begin
            if (rvalid) begin
               // Worst response wins; ID or length violations override to SLVERR.
               if (rresp > resp_q) resp_d = rresp;
               if (rid != id_q) resp_d = 2'b10;
               beat_d = beat_q + 4'd1;
               if (rlast) begin
                  if (beat_q != len_q) resp_d = 2'b10;
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // cmd_ready is held low while reset is asserted so it rises only once reset is released.
   assign cmd_ready  = st_idle && !rst;

   assign awvalid    = st_wa;
   assign awid       = st_wa ? id_q : '0;
   assign awaddr     = st_wa ? addr_q : '0;
   assign awlen      = st_wa ? {4'b0, len_q} : '0;
   assign awsize     = st_wa ? 3'(SIZE) : '0;
   assign awburst    = st_wa ? 2'b01 : '0;

   assign wvalid     = st_wd && wr_valid;
   assign wr_ready   = st_wd && wready;
   assign wdata      = st_wd ? wr_data : '0;
   assign wstrb      = st_wd ? '1 : '0;
   assign wlast      = st_wd && (beat_q == len_q);

   assign bready     = st_wr;

   assign arvalid    = st_ra;
   assign arid       = st_ra ? id_q : '0;
   assign araddr     = st_ra ? addr_q : '0;
   assign arlen      = st_ra ? {4'b0, len_q} : '0;
   assign arsize     = st_ra ? 3'(SIZE) : '0;
   assign arburst    = st_ra ? 2'b01 : '0;

   assign rready     = st_rd;
   assign rd_valid   = st_rd && rvalid;
   assign rd_data    = rd_valid ? rdata : '0;
   assign rd_last    = rd_valid && rlast;

   assign done_valid = st_done;
   assign done_resp  = st_done ? resp_q : '0;
   assign done_id    = st_done ? id_q : '0;

endmodule
